sdram_aref_ctrl: RTL and testbench

Parametrised SDRAM auto-refresh engine. It sits between the init sequencer and the command arbiter.
- Generates periodic refresh obligations.
- Accumulates postponed obligations as a debt counter.
- When granted, issues PRECHARGE-ALL followed by a burst of AUTO REFRESH commands, with tRP/tRFC spacing enforced internally.
- Flags debt overflow so the arbiter can be checked for starvation.

---
 rtl/sdram_aref_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_aref_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh engine: tracks periodic refresh debt and, when granted,
// issues PRECHARGE-ALL followed by a burst of AUTO REFRESH with tRP/tRFC spacing.
module sdram_aref_ctrl #(
    parameter int REF_INTERVAL = 750,
    parameter int REF_BURST    = 1,
    parameter int MAX_DEBT     = 8,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 7,
    parameter int ADDR_W       = 12
) (
    input  logic                          sclk,
    input  logic                          s_rst_n,
    input  logic                          flag_init_end,
    input  logic                          ref_en,
    output logic                          ref_req,
    output logic                          flag_ref_end,
    output logic [3:0]                    aref_cmd,
    output logic [ADDR_W-1:0]             sdram_addr,
    output logic [$clog2(MAX_DEBT+1)-1:0] ref_debt,
    output logic                          ref_overflow
);

    localparam int DEBT_W   = $clog2(MAX_DEBT + 1);
    localparam int CNT_W    = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int BURST_W  = $clog2(REF_BURST + 1);
    localparam int WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [3:0]        CMD_NOP  = 4'b0111;
    localparam logic [3:0]        CMD_PRE  = 4'b0010;
    localparam logic [3:0]        CMD_AREF = 4'b0001;
    localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(11'h400);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(REF_INTERVAL - 1);
    localparam logic [DEBT_W-1:0]  DEBT_MAX  = DEBT_W'(MAX_DEBT);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(REF_BURST);
    localparam logic [WAIT_W-1:0]  RP_LAST   = WAIT_W'(T_RP - 1);
    localparam logic [WAIT_W-1:0]  RFC_LAST  = WAIT_W'(T_RFC - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_WAIT_RP  = 3'd2,
        ST_AREF     = 3'd3,
        ST_WAIT_RFC = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    int_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [BURST_W-1:0]  burst_cnt_r;
    logic                tick_s;
    logic                aref_s;
    logic                grant_s;
    logic [DEBT_W-1:0]   debt_nxt_s;
    logic                ovf_nxt_s;

    // Refresh obligation tick and service-side events for the current cycle
    always_comb begin
        tick_s  = 1'b0;
        aref_s  = 1'b0;
        grant_s = 1'b0;
        if (flag_init_end && (int_cnt_r == CNT_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if (state_r == ST_AREF) begin
            aref_s = 1'b1;
        end else begin
            aref_s = 1'b0;
        end
        if ((state_r == ST_IDLE) && ref_req && ref_en) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Debt bookkeeping: tick adds, AREF subtracts, both together cancel
    always_comb begin
        debt_nxt_s = ref_debt;
        ovf_nxt_s  = ref_overflow;
        case ({tick_s, aref_s})
            2'b10: begin
                if (ref_debt == DEBT_MAX) begin
                    debt_nxt_s = ref_debt;
                    ovf_nxt_s  = 1'b1;
                end else begin
                    debt_nxt_s = ref_debt + DEBT_W'(1);
                    ovf_nxt_s  = ref_overflow;
                end
            end
            2'b01: begin
                if (ref_debt != {DEBT_W{1'b0}}) begin
                    debt_nxt_s = ref_debt - DEBT_W'(1);
                end else begin
                    debt_nxt_s = ref_debt;
                end
            end
            default: begin
                debt_nxt_s = ref_debt;
                ovf_nxt_s  = ref_overflow;
            end
        endcase
    end

    // Refresh interval counter, frozen until initialisation has finished
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            int_cnt_r <= {CNT_W{1'b0}};
        end else if (flag_init_end) begin
            if (int_cnt_r == CNT_LAST) begin
                int_cnt_r <= {CNT_W{1'b0}};
            end else begin
                int_cnt_r <= int_cnt_r + CNT_W'(1);
            end
        end else begin
            int_cnt_r <= int_cnt_r;
        end
    end

    // Pending-obligation counter and sticky overflow flag
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            ref_debt     <= {DEBT_W{1'b0}};
            ref_overflow <= 1'b0;
        end else begin
            ref_debt     <= debt_nxt_s;
            ref_overflow <= ovf_nxt_s;
        end
    end

    // Service FSM; outputs are loaded with the decode of the state being entered
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            burst_cnt_r  <= {BURST_W{1'b0}};
            ref_req      <= 1'b0;
            flag_ref_end <= 1'b0;
            aref_cmd     <= CMD_NOP;
            sdram_addr   <= {ADDR_W{1'b0}};
        end else begin
            ref_req      <= 1'b0;
            flag_ref_end <= 1'b0;
            aref_cmd     <= CMD_NOP;
            sdram_addr   <= {ADDR_W{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    burst_cnt_r <= {BURST_W{1'b0}};
                    wait_cnt_r  <= {WAIT_W{1'b0}};
                    if (grant_s) begin
                        state_r    <= ST_PRE;
                        aref_cmd   <= CMD_PRE;
                        sdram_addr <= ADDR_A10;
                    end else begin
                        state_r <= ST_IDLE;
                        ref_req <= (debt_nxt_s != {DEBT_W{1'b0}});
                    end
                end
                ST_PRE: begin
                    state_r    <= ST_WAIT_RP;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
                ST_WAIT_RP: begin
                    if (wait_cnt_r == RP_LAST) begin
                        state_r  <= ST_AREF;
                        aref_cmd <= CMD_AREF;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_AREF: begin
                    state_r     <= ST_WAIT_RFC;
                    wait_cnt_r  <= {WAIT_W{1'b0}};
                    burst_cnt_r <= burst_cnt_r + BURST_W'(1);
                end
                ST_WAIT_RFC: begin
                    if (wait_cnt_r == RFC_LAST) begin
                        // ref_debt already reflects the last AREF here
                        if ((burst_cnt_r < BURST_LIM) && (ref_debt != {DEBT_W{1'b0}})) begin
                            state_r  <= ST_AREF;
                            aref_cmd <= CMD_AREF;
                        end else begin
                            state_r      <= ST_DONE;
                            flag_ref_end <= 1'b1;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ref_req <= (debt_nxt_s != {DEBT_W{1'b0}});
                end
                default: begin
                    state_r     <= ST_IDLE;
                    wait_cnt_r  <= {WAIT_W{1'b0}};
                    burst_cnt_r <= {BURST_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Directed bench: instance A uses default parameters, instance B uses REF_BURST=4.
module tb_sdram_aref_ctrl;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    logic        sclk;
    logic        rst_a, init_a, en_a;
    logic        rst_b, init_b, en_b;
    logic        req_a, flag_a, ovf_a, req_b, flag_b, ovf_b;
    logic [3:0]  cmd_a, cmd_b, debt_a, debt_b;
    logic [11:0] addr_a, addr_b;
    logic        sel;
    int          nvec;
    int          nerr;

    wire [3:0]  m_cmd  = sel ? cmd_b  : cmd_a;
    wire [11:0] m_addr = sel ? addr_b : addr_a;
    wire [3:0]  m_debt = sel ? debt_b : debt_a;
    wire        m_req  = sel ? req_b  : req_a;
    wire        m_flag = sel ? flag_b : flag_a;
    wire        m_ovf  = sel ? ovf_b  : ovf_a;

    sdram_aref_ctrl #(
        .REF_INTERVAL(750), .REF_BURST(1), .MAX_DEBT(8),
        .T_RP(2), .T_RFC(7), .ADDR_W(12)
    ) u_dut_a (
        .sclk(sclk), .s_rst_n(rst_a), .flag_init_end(init_a), .ref_en(en_a),
        .ref_req(req_a), .flag_ref_end(flag_a), .aref_cmd(cmd_a),
        .sdram_addr(addr_a), .ref_debt(debt_a), .ref_overflow(ovf_a)
    );

    sdram_aref_ctrl #(
        .REF_INTERVAL(750), .REF_BURST(4), .MAX_DEBT(8),
        .T_RP(2), .T_RFC(7), .ADDR_W(12)
    ) u_dut_b (
        .sclk(sclk), .s_rst_n(rst_b), .flag_init_end(init_b), .ref_en(en_b),
        .ref_req(req_b), .flag_ref_end(flag_b), .aref_cmd(cmd_b),
        .sdram_addr(addr_b), .ref_debt(debt_b), .ref_overflow(ovf_b)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input logic v);
        if (sel) en_b = v;
        else     en_a = v;
    endtask

    task automatic chk_idle_reset();
        chk("rst_cmd",  m_cmd,  NOP);
        chk("rst_addr", m_addr, 12'h000);
        chk("rst_debt", m_debt, 4'd0);
        chk("rst_req",  m_req,  1'b0);
        chk("rst_flag", m_flag, 1'b0);
        chk("rst_ovf",  m_ovf,  1'b0);
    endtask

    // One granted service with n_aref AREF commands on the selected instance
    task automatic svc(input int n_aref, input logic [3:0] debt_after, input logic req_after);
        set_en(1'b1);
        step();
        chk("pre_cmd",  m_cmd,  PRE);
        chk("pre_addr", m_addr, 12'h400);
        set_en(1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rp_nop", m_cmd, NOP);
        end
        for (int k = 0; k < n_aref; k++) begin
            step();
            chk("aref_cmd",  m_cmd,  AREF);
            chk("aref_addr", m_addr, 12'h000);
            for (int i = 0; i < 7; i++) begin
                step();
                chk("rfc_nop",  m_cmd,  NOP);
                chk("rfc_flag", m_flag, 1'b0);
            end
        end
        step();
        chk("done_flag", m_flag, 1'b1);
        chk("done_cmd",  m_cmd,  NOP);
        chk("done_req",  m_req,  1'b0);
        step();
        chk("end_flag", m_flag, 1'b0);
        chk("end_debt", m_debt, debt_after);
        chk("end_req",  m_req,  req_after);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        sel = 1'b0;
        rst_a = 1'b0; init_a = 1'b0; en_a = 1'b0;
        rst_b = 1'b0; init_b = 1'b0; en_b = 1'b0;
        step();
        rst_a = 1'b1;
        rst_b = 1'b1;
        sel = 1'b0;
        chk_idle_reset();
        sel = 1'b1;
        chk_idle_reset();

        // Interval counter must not run before init completes
        sel = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            chk("noinit_req",  m_req,  1'b0);
            chk("noinit_debt", m_debt, 4'd0);
            chk("noinit_cmd",  m_cmd,  NOP);
        end

        // First obligation after exactly 750 cycles, then a single service
        init_a = 1'b1;
        repeat (749) step();
        chk("t2_debt_749", m_debt, 4'd0);
        chk("t2_req_749",  m_req,  1'b0);
        step();
        chk("t2_debt_750", m_debt, 4'd1);
        chk("t2_req_750",  m_req,  1'b1);
        svc(1, 4'd0, 1'b0);

        // Tick coincident with AREF: debt holds at 2, request returns after DONE
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        chk_idle_reset();
        repeat (2245) step();
        chk("t5_debt_pre", m_debt, 4'd2);
        en_a = 1'b1;
        step();
        chk("t5_pre", m_cmd, PRE);
        en_a = 1'b0;
        repeat (3) step();
        chk("t5_aref",      m_cmd,  AREF);
        chk("t5_debt_aref", m_debt, 4'd2);
        step();
        chk("t5_debt_after", m_debt, 4'd2);
        repeat (6) step();
        chk("t5_rfc_nop", m_cmd, NOP);
        step();
        chk("t5_done_flag", m_flag, 1'b1);
        step();
        chk("t5_req",  m_req,  1'b1);
        chk("t5_debt", m_debt, 4'd2);

        // Reset during WAIT_RFC; a pulse between edges is ignored
        en_a = 1'b1;
        step();
        chk("t6_pre", m_cmd, PRE);
        en_a = 1'b0;
        repeat (3) step();
        chk("t6_aref", m_cmd, AREF);
        step();
        chk("t6_rfc_debt", m_debt, 4'd1);
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
        step();
        chk("t6_glitch_debt", m_debt, 4'd1);
        chk("t6_glitch_cmd",  m_cmd,  NOP);
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        chk_idle_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_no_flag", m_flag, 1'b0);
            chk("t6_cmd",     m_cmd,  NOP);
        end

        // Burst of three AREFs with a single PRE
        sel = 1'b1;
        rst_b = 1'b0;
        init_b = 1'b1;
        step();
        rst_b = 1'b1;
        chk_idle_reset();
        repeat (1500) step();
        chk("t3_debt2", m_debt, 4'd2);
        repeat (750) step();
        chk("t3_debt3", m_debt, 4'd3);
        chk("t3_req",   m_req,  1'b1);
        svc(3, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_req_idle", m_req, 1'b0);
        end

        // Debt saturation and sticky overflow
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        chk_idle_reset();
        repeat (5999) step();
        chk("t4_debt7", m_debt, 4'd7);
        step();
        chk("t4_debt8", m_debt, 4'd8);
        chk("t4_ovf0",  m_ovf,  1'b0);
        repeat (749) step();
        chk("t4_ovf_pre", m_ovf, 1'b0);
        step();
        chk("t4_debt_sat", m_debt, 4'd8);
        chk("t4_ovf1",     m_ovf,  1'b1);
        svc(4, 4'd4, 1'b1);
        chk("t4_ovf_sticky", m_ovf, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
